multicycle_control: RTL and testbench

- Multi-cycle sequencing controller for the RV32 datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the existing datapath control fields: control_ALU, S_Mux_A/B/C, REG_RD/WR, MEM_RD/WR.
- Adds PC/IR write enables and a shared instruction/data memory handshake.
- Sits between the instruction register, the single memory port and the register file/ALU datapath; replaces per-cycle combinational decode.

---
 rtl/rv_ctrl_pkg.sv | 51 +++++
 rtl/ctrl_decode.sv | 52 +++++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle controller: opcodes, FSM states,
// instruction classes and datapath mux/ALU select values.
package rv_ctrl_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned SEL_W = 2;

    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ADDI   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LUI     = 3'd1,
        CLS_R       = 3'd2,
        CLS_ADDI    = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_BRANCH  = 3'd6
    } cls_e;

    localparam logic SEL_A_PC4 = 1'b0;
    localparam logic SEL_A_BR  = 1'b1;

    localparam logic [SEL_W-1:0] SEL_B_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_B_IIMM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_B_SIMM = 2'b10;
    localparam logic [SEL_W-1:0] SEL_B_UIMM = 2'b11;

    localparam logic [SEL_W-1:0] SEL_C_UIMM = 2'b00;
    localparam logic [SEL_W-1:0] SEL_C_ALU  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_C_MEM  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_C_NONE = 2'b11;

    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class plus the ALU-B source,
// writeback source and ALU operation that class uses.
module ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       funct7_5,
    output cls_e       cls_c,
    output logic [1:0] sel_b_c,
    output logic [1:0] sel_c_c,
    output logic [1:0] alu_op_c
);

    always_comb begin
        cls_c    = CLS_ILLEGAL;
        sel_b_c  = SEL_B_RS2;
        sel_c_c  = SEL_C_NONE;
        alu_op_c = ALU_ADD;
        case (opcode)
            OP_LUI: begin
                cls_c   = CLS_LUI;
                sel_b_c = SEL_B_UIMM;
                sel_c_c = SEL_C_UIMM;
            end
            OP_R: begin
                cls_c    = CLS_R;
                sel_c_c  = SEL_C_ALU;
                alu_op_c = funct7_5 ? ALU_SUB : ALU_ADD;
            end
            OP_ADDI: begin
                cls_c   = CLS_ADDI;
                sel_b_c = SEL_B_IIMM;
                sel_c_c = SEL_C_ALU;
            end
            OP_LOAD: begin
                cls_c   = CLS_LOAD;
                sel_b_c = SEL_B_IIMM;
                sel_c_c = SEL_C_MEM;
            end
            OP_STORE: begin
                cls_c   = CLS_STORE;
                sel_b_c = SEL_B_SIMM;
            end
            OP_BRANCH: begin
                cls_c    = CLS_BRANCH;
                alu_op_c = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 datapath,
// with shared instruction/data memory handshake and retired-instruction count.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             funct7_5,
    input  logic             cero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             IR_WR,
    output logic             PC_WR,
    output logic             S_Mux_A,
    output logic [1:0]       S_Mux_B,
    output logic [1:0]       S_Mux_C,
    output logic [1:0]       control_ALU,
    output logic             REG_RD,
    output logic             REG_WR,
    output logic [2:0]       state_o,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q;
    state_e           state_d;
    logic [OPC_W-1:0] op_q;
    logic             f7_q;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q;
    logic             retire;

    cls_e             cls;
    logic [1:0]       sel_b;
    logic [1:0]       sel_c;
    logic [1:0]       alu_op;

    ctrl_decode u_decode (
        .opcode   (op_q),
        .funct7_5 (f7_q),
        .cls_c    (cls),
        .sel_b_c  (sel_b),
        .sel_c_c  (sel_c),
        .alu_op_c (alu_op)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched instruction fields, retire counter and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            f7_q      <= 1'b0;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            if (state_q == FETCH && mem_ready) begin
                op_q <= opcode;
                f7_q <= funct7_5;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_d == TRAP) begin
                trap_q <= 1'b1;
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        MEM_RD      = 1'b0;
        MEM_WR      = 1'b0;
        IR_WR       = 1'b0;
        PC_WR       = 1'b0;
        S_Mux_A     = SEL_A_PC4;
        S_Mux_B     = SEL_B_RS2;
        S_Mux_C     = SEL_C_NONE;
        control_ALU = ALU_ADD;
        REG_RD      = 1'b0;
        REG_WR      = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                MEM_RD  = 1'b1;
                IR_WR   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                REG_RD = (cls != CLS_LUI);
                PC_WR  = 1'b1;
                case (cls)
                    CLS_LUI:     state_d = WB;
                    CLS_ILLEGAL: begin
                        if (TRAP_ON_ILLEGAL) state_d = TRAP;
                        else                 retire  = 1'b1;
                    end
                    default:     state_d = EXEC;
                endcase
            end
            EXEC: begin
                REG_RD      = 1'b1;
                S_Mux_B     = sel_b;
                control_ALU = alu_op;
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    CLS_BRANCH: begin
                        PC_WR   = cero;
                        S_Mux_A = SEL_A_BR;
                        retire  = 1'b1;
                    end
                    default: state_d = WB;
                endcase
            end
            MEM: begin
                mem_req     = 1'b1;
                mem_sel     = 1'b1;
                MEM_RD      = (cls == CLS_LOAD);
                MEM_WR      = (cls == CLS_STORE);
                S_Mux_B     = sel_b;
                control_ALU = alu_op;
                if (mem_ready) begin
                    if (cls == CLS_LOAD) state_d = WB;
                    else                 retire  = 1'b1;
                end
            end
            WB: begin
                REG_WR      = 1'b1;
                S_Mux_B     = sel_b;
                S_Mux_C     = sel_c;
                control_ALU = alu_op;
                retire      = 1'b1;
            end
            TRAP: ;
            default: state_d = IDLE;
        endcase

        // A retiring instruction hands off to the next fetch only while run is held
        if (retire) state_d = run ? FETCH : IDLE;
    end

    assign state_o = state_q;
    assign trap    = trap_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: walks each instruction
// class cycle by cycle and compares state and the full control vector.
module tb_multicycle_control;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        funct7_5 = 1'b0;
    logic        cero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_sel, MEM_RD, MEM_WR, IR_WR, PC_WR, S_Mux_A;
    logic [1:0]  S_Mux_B, S_Mux_C, control_ALU;
    logic        REG_RD, REG_WR, trap;
    logic [2:0]  state_o;
    logic [31:0] instret;
    logic [15:0] ctl_obs;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] inact, fetch_rdy, fetch_wait, dec, dec_lui;

    multicycle_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .funct7_5    (funct7_5),
        .cero        (cero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_sel     (mem_sel),
        .MEM_RD      (MEM_RD),
        .MEM_WR      (MEM_WR),
        .IR_WR       (IR_WR),
        .PC_WR       (PC_WR),
        .S_Mux_A     (S_Mux_A),
        .S_Mux_B     (S_Mux_B),
        .S_Mux_C     (S_Mux_C),
        .control_ALU (control_ALU),
        .REG_RD      (REG_RD),
        .REG_WR      (REG_WR),
        .state_o     (state_o),
        .trap        (trap),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {mem_req, mem_sel, MEM_RD, MEM_WR, IR_WR, PC_WR, S_Mux_A,
                      S_Mux_B, S_Mux_C, control_ALU, REG_RD, REG_WR, trap};

    // Expected control vector, field order matches ctl_obs
    function automatic logic [15:0] ctl(input int req, input int sel, input int rd,
                                        input int wr, input int irw, input int pcw,
                                        input int sa, input int sb, input int sc,
                                        input int alu, input int rrd, input int rwr,
                                        input int trp);
        return {1'(req), 1'(sel), 1'(rd), 1'(wr), 1'(irw), 1'(pcw), 1'(sa),
                2'(sb), 2'(sc), 2'(alu), 1'(rrd), 1'(rwr), 1'(trp)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cyc(input string tag, input logic [2:0] st, input logic [15:0] c);
        #1;
        check({tag, " state"}, 32'(state_o), 32'(st));
        check({tag, " ctl"}, 32'(ctl_obs), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        inact      = ctl(0,0,0,0,0,0,0, 0,3,0, 0,0,0);
        fetch_rdy  = ctl(1,0,1,0,1,0,0, 0,3,0, 0,0,0);
        fetch_wait = ctl(1,0,1,0,0,0,0, 0,3,0, 0,0,0);
        dec        = ctl(0,0,0,0,0,1,0, 0,3,0, 1,0,0);
        dec_lui    = ctl(0,0,0,0,0,1,0, 0,3,0, 0,0,0);

        // Reset held while run is high
        run = 1'b1; mem_ready = 1'b1; opcode = OPC_R;
        repeat (2) tick();
        check_cyc("reset", S_IDLE, inact);
        check("reset instret", instret, 32'd0);
        run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick(); check_cyc("idle hold", S_IDLE, inact);
        run = 1'b1;

        // add then sub
        tick(); opcode = OPC_R; funct7_5 = 1'b0; check_cyc("add fetch", S_FETCH, fetch_rdy);
        tick(); check_cyc("add decode", S_DECODE, dec);
        tick(); check_cyc("add exec", S_EXEC, ctl(0,0,0,0,0,0,0, 0,3,0, 1,0,0));
        tick(); check_cyc("add wb", S_WB, ctl(0,0,0,0,0,0,0, 0,1,0, 0,1,0));
        tick(); funct7_5 = 1'b1; check_cyc("sub fetch", S_FETCH, fetch_rdy);
        check("instret after add", instret, 32'd1);
        tick(); funct7_5 = 1'b0; check_cyc("sub decode", S_DECODE, dec);
        tick(); check_cyc("sub exec", S_EXEC, ctl(0,0,0,0,0,0,0, 0,3,1, 1,0,0));
        tick(); check_cyc("sub wb", S_WB, ctl(0,0,0,0,0,0,0, 0,1,1, 0,1,0));

        // load with three wait cycles in MEM
        tick(); opcode = OPC_LOAD; check_cyc("load fetch", S_FETCH, fetch_rdy);
        check("instret after sub", instret, 32'd2);
        tick(); check_cyc("load decode", S_DECODE, dec);
        tick(); check_cyc("load exec", S_EXEC, ctl(0,0,0,0,0,0,0, 1,3,0, 1,0,0));
        for (int i = 0; i < 3; i++) begin
            tick(); mem_ready = 1'b0;
            check_cyc("load mem wait", S_MEM, ctl(1,1,1,0,0,0,0, 1,3,0, 0,0,0));
        end
        tick(); mem_ready = 1'b1; check_cyc("load mem done", S_MEM, ctl(1,1,1,0,0,0,0, 1,3,0, 0,0,0));
        tick(); check_cyc("load wb", S_WB, ctl(0,0,0,0,0,0,0, 1,2,0, 0,1,0));

        // branch taken, then not taken
        tick(); opcode = OPC_BR; cero = 1'b1; check_cyc("beq1 fetch", S_FETCH, fetch_rdy);
        check("instret after load", instret, 32'd3);
        tick(); check_cyc("beq1 decode", S_DECODE, dec);
        tick(); check_cyc("beq1 exec", S_EXEC, ctl(0,0,0,0,0,1,1, 0,3,1, 1,0,0));
        tick(); cero = 1'b0; check_cyc("beq0 fetch", S_FETCH, fetch_rdy);
        check("instret after beq1", instret, 32'd4);
        tick(); check_cyc("beq0 decode", S_DECODE, dec);
        tick(); check_cyc("beq0 exec", S_EXEC, ctl(0,0,0,0,0,0,1, 0,3,1, 1,0,0));

        // store
        tick(); opcode = OPC_STORE; check_cyc("store fetch", S_FETCH, fetch_rdy);
        check("instret after beq0", instret, 32'd5);
        tick(); check_cyc("store decode", S_DECODE, dec);
        tick(); check_cyc("store exec", S_EXEC, ctl(0,0,0,0,0,0,0, 2,3,0, 1,0,0));
        tick(); check_cyc("store mem", S_MEM, ctl(1,1,0,1,0,0,0, 2,3,0, 0,0,0));

        // lui with run dropped mid-instruction
        tick(); opcode = OPC_LUI; check_cyc("lui fetch", S_FETCH, fetch_rdy);
        check("instret after store", instret, 32'd6);
        tick(); run = 1'b0; check_cyc("lui decode", S_DECODE, dec_lui);
        tick(); check_cyc("lui wb", S_WB, ctl(0,0,0,0,0,0,0, 3,0,0, 0,1,0));
        tick(); check_cyc("stop idle", S_IDLE, inact);
        check("instret after lui", instret, 32'd7);
        tick(); check_cyc("stop idle hold", S_IDLE, inact);
        run = 1'b1;

        // illegal opcode with a fetch wait cycle
        tick(); opcode = OPC_BAD; mem_ready = 1'b0; check_cyc("bad fetch wait", S_FETCH, fetch_wait);
        tick(); mem_ready = 1'b1; check_cyc("bad fetch", S_FETCH, fetch_rdy);
        tick(); check_cyc("bad decode", S_DECODE, dec);
        for (int i = 0; i < 4; i++) begin
            tick(); check_cyc("trap hold", S_TRAP, ctl(0,0,0,0,0,0,0, 0,3,0, 0,0,1));
        end
        check("instret in trap", instret, 32'd7);

        // reset pulse leaves TRAP
        @(negedge clk); rst_n = 1'b0;
        check_cyc("trap reset", S_IDLE, inact);
        check("trap reset instret", instret, 32'd0);
        @(negedge clk); rst_n = 1'b1; opcode = OPC_R;
        tick(); check_cyc("post reset fetch", S_FETCH, fetch_rdy);
        tick(); check_cyc("abort decode", S_DECODE, dec);

        // asynchronous reset mid-DECODE kills PC_WR at once
        #1 rst_n = 1'b0;
        check_cyc("abort reset", S_IDLE, inact);
        @(negedge clk); rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
